// File: rtl/dffram_arbiter_if.sv
// Requester-side bus of the shared DFFRAM arbiter: per-port request/lock/write
// fields in, one-hot grant and read-return out.
interface dffram_arbiter_if #(
   parameter int NPORTS = 2,
   parameter int WSIZE  = 4,
   parameter int ADDR_W = 10
);
   logic [NPORTS-1:0]                 req_i;
   logic [NPORTS-1:0]                 lock_i;
   logic [NPORTS-1:0][WSIZE-1:0]      we_i;
   logic [NPORTS-1:0][ADDR_W-1:0]     addr_i;
   logic [NPORTS-1:0][WSIZE*8-1:0]    wdata_i;
   logic [NPORTS-1:0]                 gnt_o;
   logic [NPORTS-1:0]                 rvalid_o;
   logic [WSIZE*8-1:0]                rdata_o;

   modport master (
      output req_i, lock_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, lock_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one single-port DFFRAM (byte WE, 1-cycle read)
// between NPORTS requesters, with a capped burst lock for line fills.
module dffram_arbiter #(
   parameter int NPORTS    = 2,
   parameter int WSIZE     = 4,
   parameter int ADDR_W    = 10,
   parameter int MAX_BURST = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   dffram_arbiter_if.slave     bus,
   output logic                ram_en_o,
   output logic [WSIZE-1:0]    ram_we_o,
   output logic [ADDR_W-1:0]   ram_a_o,
   output logic [WSIZE*8-1:0]  ram_di_o,
   input  logic [WSIZE*8-1:0]  ram_do_i
);
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic {ARB, LOCKED} state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [PW-1:0]        rr_q, rr_d;
   logic [7:0]           burst_q, burst_d;
   logic [NPORTS-1:0]    rvalid_q, rvalid_d;
   logic [ADDR_W-1:0]    a_q;
   logic [WSIZE*8-1:0]   di_q;

   logic [NPORTS-1:0]    gnt_c;
   logic [PW-1:0]        sel;
   logic [PW-1:0]        win;
   logic                 found;
   logic                 en;

   // First requester strictly after rr_q, wrapping modulo NPORTS.
   always_comb begin
      found = 1'b0;
      win   = rr_q;
      for (int i = 1; i <= NPORTS; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % NPORTS;
         if (!found && bus.req_i[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      burst_d = burst_q;
      gnt_c   = '0;
      sel     = win;
      case (state_q)
         ARB: begin
            if (found) begin
               gnt_c[win] = 1'b1;
               rr_d       = win;
               if (bus.lock_i[win] && (MAX_BURST > 1)) begin
                  state_d = LOCKED;
                  owner_d = win;
                  burst_d = 8'd1;
               end
            end
         end
         LOCKED: begin
            sel = owner_q;
            if (bus.req_i[owner_q]) begin
               gnt_c[owner_q] = 1'b1;
               burst_d        = burst_q + 8'd1;
               if (!bus.lock_i[owner_q] || (burst_q + 8'd1 == 8'(MAX_BURST)))
                  state_d = ARB;
            end else begin
               // An idle owner gives the RAM back immediately.
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Grant is combinational but must read as zero while reset is held.
   assign bus.gnt_o    = rst_ni ? gnt_c : '0;
   assign en           = |bus.gnt_o;
   assign rvalid_d     = (~|bus.we_i[sel]) ? bus.gnt_o : '0;

   assign ram_en_o     = en;
   assign ram_we_o     = en ? bus.we_i[sel]    : '0;
   assign ram_a_o      = en ? bus.addr_i[sel]  : a_q;
   assign ram_di_o     = en ? bus.wdata_i[sel] : di_q;

   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = ram_do_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ARB;
         owner_q  <= '0;
         rr_q     <= PW'(NPORTS - 1);
         burst_q  <= '0;
         rvalid_q <= '0;
         a_q      <= '0;
         di_q     <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         burst_q  <= burst_d;
         rvalid_q <= rvalid_d;
         if (en) begin
            a_q  <= ram_a_o;
            di_q <= ram_di_o;
         end
      end
   end
endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural byte-write DFFRAM model.
module tb_dffram_arbiter;
   localparam int NPORTS = 2;
   localparam int WSIZE  = 4;
   localparam int ADDR_W = 10;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ram_en_o;
   logic [3:0]  ram_we_o;
   logic [9:0]  ram_a_o;
   logic [31:0] ram_di_o;
   logic [31:0] ram_do;
   logic [31:0] mem [1024];

   int checks = 0;
   int fails  = 0;

   dffram_arbiter_if #(.NPORTS(NPORTS), .WSIZE(WSIZE), .ADDR_W(ADDR_W)) bus ();

   dffram_arbiter #(.NPORTS(NPORTS), .WSIZE(WSIZE), .ADDR_W(ADDR_W), .MAX_BURST(8)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .bus      (bus),
      .ram_en_o (ram_en_o),
      .ram_we_o (ram_we_o),
      .ram_a_o  (ram_a_o),
      .ram_di_o (ram_di_o),
      .ram_do_i (ram_do)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (ram_en_o) begin
         for (int b = 0; b < 4; b++)
            if (ram_we_o[b]) mem[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
         if (ram_we_o == 4'b0) ram_do <= mem[ram_a_o];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic setp(input int p, input bit req, input bit lock, input logic [3:0] we,
                       input logic [9:0] a, input logic [31:0] d);
      bus.req_i[p]   = req;
      bus.lock_i[p]  = lock;
      bus.we_i[p]    = we;
      bus.addr_i[p]  = a;
      bus.wdata_i[p] = d;
   endtask

   task automatic idle();
      setp(0, 0, 0, 4'h0, 10'h0, 32'h0);
      setp(1, 0, 0, 4'h0, 10'h0, 32'h0);
   endtask

   initial begin
      int n0, n1;
      ram_do = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      idle();
      rst_ni = 1'b0;
      setp(0, 1, 0, 4'h0, 10'h0, 32'h0);
      setp(1, 1, 0, 4'h0, 10'h1, 32'h0);
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_gnt",    32'(bus.gnt_o),    32'h0);
      chk("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      chk("rst_en",     32'(ram_en_o),     32'h0);
      chk("rst_we",     32'(ram_we_o),     32'h0);
      @(negedge clk_i);
      idle();
      rst_ni = 1'b1;

      // single port: fill then read back
      for (int a = 0; a < 1024; a++) begin
         @(negedge clk_i);
         setp(0, 1, 0, 4'hF, 10'(a), 32'(a));
         #1 chk("wr_gnt", 32'(bus.gnt_o), 32'h1);
      end
      for (int a = 0; a <= 1024; a++) begin
         @(negedge clk_i);
         if (a < 1024) setp(0, 1, 0, 4'h0, 10'(a), 32'h0);
         else          idle();
         #1;
         if (a < 1024) chk("rd_gnt", 32'(bus.gnt_o), 32'h1);
         if (a == 0) chk("wr_no_rvalid", 32'(bus.rvalid_o), 32'h0);
         else begin
            chk("rd_rvalid", 32'(bus.rvalid_o), 32'h1);
            chk("rd_data",   bus.rdata_o,       32'(a - 1));
         end
      end

      // contention without lock, from reset
      @(negedge clk_i); rst_ni = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         setp(0, 1, 0, 4'h0, 10'h0, 32'h0);
         setp(1, 1, 0, 4'h0, 10'h1, 32'h0);
         #1;
         chk("cont_gnt", 32'(bus.gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         if (bus.gnt_o[0]) n0++;
         if (bus.gnt_o[1]) n1++;
      end
      chk("cont_n0", 32'(n0), 32'd50);
      chk("cont_n1", 32'(n1), 32'd50);
      @(negedge clk_i); idle();

      // burst lock: port 1 writes 0x100..0x103, port 0 waits to read 0x000
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (i < 4) setp(1, 1, (i < 3), 4'hF, 10'h100 + 10'(i), 32'hA000_0000 + 32'(i));
         else       setp(1, 0, 0, 4'h0, 10'h0, 32'h0);
         if (i >= 1) setp(0, 1, 0, 4'h0, 10'h000, 32'h0);
         #1 chk("lock_gnt", 32'(bus.gnt_o), (i < 4) ? 32'h2 : 32'h1);
      end
      @(negedge clk_i); idle();
      #1;
      chk("lock_rvalid", 32'(bus.rvalid_o), 32'h1);
      chk("lock_rdata",  bus.rdata_o,       32'h0);

      // burst cap: port 1 holds lock, port 0 reads 0x101
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         setp(1, 1, 1, 4'hF, 10'h300, 32'h5555_0000 + 32'(i));
         if (i >= 1 && i <= 8) setp(0, 1, 0, 4'h0, 10'h101, 32'h0);
         else                  setp(0, 0, 0, 4'h0, 10'h0, 32'h0);
         #1 chk("cap_gnt", 32'(bus.gnt_o), (i == 8) ? 32'h1 : 32'h2);
         if (i == 9) begin
            chk("cap_rvalid", 32'(bus.rvalid_o), 32'h1);
            chk("cap_rdata",  bus.rdata_o,       32'hA000_0001);
         end
      end
      @(negedge clk_i); idle();

      // byte enables
      @(negedge clk_i); setp(0, 1, 0, 4'hF, 10'h005, 32'hDEAD_BEEF);
      #1 chk("be_gnt0", 32'(bus.gnt_o), 32'h1);
      @(negedge clk_i); idle(); setp(1, 1, 0, 4'b0100, 10'h005, 32'h1122_3344);
      #1;
      chk("be_gnt1", 32'(bus.gnt_o), 32'h2);
      chk("be_we",   32'(ram_we_o),  32'h4);
      @(negedge clk_i); idle(); setp(0, 1, 0, 4'h0, 10'h005, 32'h0);
      #1 chk("be_rd_gnt", 32'(bus.gnt_o), 32'h1);
      @(negedge clk_i); idle();
      #1;
      chk("be_rdata", bus.rdata_o, 32'hDE22_BEEF);
      chk("idle_en",  32'(ram_en_o), 32'h0);
      chk("idle_we",  32'(ram_we_o), 32'h0);
      chk("idle_a",   32'(ram_a_o),  32'h005);

      // reset mid-lock with a read pending
      @(negedge clk_i); setp(1, 1, 1, 4'h0, 10'h005, 32'h0);
      #1 chk("rl_gnt", 32'(bus.gnt_o), 32'h2);
      @(negedge clk_i); setp(0, 1, 0, 4'h0, 10'h000, 32'h0);
      #1;
      chk("rl_gnt2",   32'(bus.gnt_o),    32'h2);
      chk("rl_rvalid", 32'(bus.rvalid_o), 32'h2);
      rst_ni = 1'b0;
      #1;
      chk("rl_rst_gnt",    32'(bus.gnt_o),    32'h0);
      chk("rl_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      chk("rl_rst_en",     32'(ram_en_o),     32'h0);
      @(negedge clk_i); rst_ni = 1'b1;
      #1;
      chk("rl_post_gnt",    32'(bus.gnt_o),    32'h1);
      chk("rl_post_rvalid", 32'(bus.rvalid_o), 32'h0);
      @(negedge clk_i); idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
